// File: rtl/mfp_seven_segment_scanner_if.sv
// Host-side bus of the seven-segment scanner: digit/dp/enable write port,
// live brightness, and the registered display drive.
interface mfp_seven_segment_scanner_if #(
    parameter int unsigned DIGITS = 8
);
    logic [31:0]       wd;
    logic              we;
    logic [7:0]        dp_wd;
    logic [7:0]        en_wd;
    logic [3:0]        brightness;
    logic [6:0]        seg_n;
    logic              dp_n;
    logic [DIGITS-1:0] an_n;
    logic              frame_done;

    modport master (
        output wd, we, dp_wd, en_wd, brightness,
        input  seg_n, dp_n, an_n, frame_done
    );

    modport slave (
        input  wd, we, dp_wd, en_wd, brightness,
        output seg_n, dp_n, an_n, frame_done
    );
endinterface

// File: rtl/mfp_seven_segment_scanner.sv
// Multiplexed seven-segment scanner with PWM brightness per digit slot and
// frame-synchronous shadow update of the displayed digits.
module mfp_seven_segment_scanner #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned TICK   = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mfp_seven_segment_scanner_if.slave    bus
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned NIB_W = 4 * DIGITS;
    localparam logic [15:0]      PRESC_LAST = 16'(TICK - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    // Scan counters
    logic [15:0]      presc_q, presc_d;
    logic [3:0]       phase_q, phase_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    // Write staging and frame-stable shadow copy
    logic                   pending_q,   pending_d;
    logic [DIGITS-1:0][3:0] stage_nib_q, stage_nib_d;
    logic [DIGITS-1:0]      stage_dp_q,  stage_dp_d;
    logic [DIGITS-1:0]      stage_en_q,  stage_en_d;
    logic [DIGITS-1:0][3:0] shadow_nib_q, shadow_nib_d;
    logic [DIGITS-1:0]      shadow_dp_q,  shadow_dp_d;
    logic [DIGITS-1:0]      shadow_en_q,  shadow_en_d;

    // Registered display drive
    logic [6:0]        seg_n_q, seg_n_d;
    logic              dp_n_q,  dp_n_d;
    logic [DIGITS-1:0] an_n_q,  an_n_d;
    logic              frame_done_q, frame_done_d;

    logic tick_c;
    logic wrap_c;
    logic lit_c;

    // Active-low {g,f,e,d,c,b,a} pattern for a hex digit
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        presc_d      = presc_q;
        phase_d      = phase_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        stage_nib_d  = stage_nib_q;
        stage_dp_d   = stage_dp_q;
        stage_en_d   = stage_en_q;
        shadow_nib_d = shadow_nib_q;
        shadow_dp_d  = shadow_dp_q;
        shadow_en_d  = shadow_en_q;
        seg_n_d      = 7'h7F;
        dp_n_d       = 1'b1;
        an_n_d       = '1;
        frame_done_d = 1'b0;
        tick_c       = (presc_q == PRESC_LAST);
        wrap_c       = 1'b0;
        lit_c        = 1'b0;

        // Prescaler -> phase -> digit index
        presc_d = tick_c ? 16'd0 : presc_q + 16'd1;
        if (tick_c) begin
            phase_d = phase_q + 4'd1;
            if (phase_q == 4'hF) begin
                idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                wrap_c = (idx_q == IDX_LAST);
            end
        end
        frame_done_d = wrap_c;

        // Shadow swaps only at the frame boundary; a coincident write wins over staging
        if (frame_done_q) begin
            if (bus.we) begin
                shadow_nib_d = bus.wd[NIB_W-1:0];
                shadow_dp_d  = bus.dp_wd[DIGITS-1:0];
                shadow_en_d  = bus.en_wd[DIGITS-1:0];
            end else if (pending_q) begin
                shadow_nib_d = stage_nib_q;
                shadow_dp_d  = stage_dp_q;
                shadow_en_d  = stage_en_q;
            end
            pending_d = 1'b0;
        end else if (bus.we) begin
            stage_nib_d = bus.wd[NIB_W-1:0];
            stage_dp_d  = bus.dp_wd[DIGITS-1:0];
            stage_en_d  = bus.en_wd[DIGITS-1:0];
            pending_d   = 1'b1;
        end

        // Uses the post-swap shadow so the first cycle of a frame already shows new data
        lit_c = (phase_q < bus.brightness) && shadow_en_d[idx_q];
        if (lit_c) begin
            an_n_d[idx_q] = 1'b0;
            seg_n_d       = hex_seg(shadow_nib_d[idx_q]);
            dp_n_d        = ~shadow_dp_d[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            phase_q      <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            stage_nib_q  <= '0;
            stage_dp_q   <= '0;
            stage_en_q   <= '0;
            shadow_nib_q <= '0;
            shadow_dp_q  <= '0;
            shadow_en_q  <= '0;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            stage_nib_q  <= stage_nib_d;
            stage_dp_q   <= stage_dp_d;
            stage_en_q   <= stage_en_d;
            shadow_nib_q <= shadow_nib_d;
            shadow_dp_q  <= shadow_dp_d;
            shadow_en_q  <= shadow_en_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_mfp_seven_segment_scanner.sv
// Randomized bench for the seven-segment scanner against a cycle-count
// reference model (DIGITS=4, TICK=2, 128-cycle frames).
module tb_mfp_seven_segment_scanner;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned TICK   = 2;
    localparam int          FRAME  = DIGITS * 16 * TICK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mfp_seven_segment_scanner_if #(.DIGITS(DIGITS)) bus ();

    mfp_seven_segment_scanner #(.DIGITS(DIGITS), .TICK(TICK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time since reset release plus what is shown / waiting
    int         k;
    logic [3:0] m_nib [DIGITS];
    logic       m_en  [DIGITS];
    logic       m_dp  [DIGITS];
    logic [3:0] w_nib [DIGITS];
    logic       w_en  [DIGITS];
    logic       w_dp  [DIGITS];
    bit         w_valid;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [DIGITS-1:0] exp_an;
    logic       exp_fd;
    logic [3:0] bright;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at k=%0d t=%0t: got %h, expected %h", tag, k, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        w_valid = 0;
        for (int i = 0; i < DIGITS; i++) begin
            m_nib[i] = 0; m_en[i] = 0; m_dp[i] = 0;
            w_nib[i] = 0; w_en[i] = 0; w_dp[i] = 0;
        end
        exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = '1; exp_fd = 1'b0;
    endtask

    // One clock of the model: cycle k ends with the given inputs sampled
    task automatic model_edge(input bit we, input logic [31:0] wd, input logic [7:0] dp,
                              input logic [7:0] en, input logic [3:0] br);
        bit boundary;
        int ph, id;
        boundary = (k > 0) && (k % FRAME == 0);
        if (boundary) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (we) begin
                    m_nib[i] = wd[4*i +: 4]; m_en[i] = en[i]; m_dp[i] = dp[i];
                end else if (w_valid) begin
                    m_nib[i] = w_nib[i]; m_en[i] = w_en[i]; m_dp[i] = w_dp[i];
                end
            end
            w_valid = 0;
        end else if (we) begin
            for (int i = 0; i < DIGITS; i++) begin
                w_nib[i] = wd[4*i +: 4]; w_en[i] = en[i]; w_dp[i] = dp[i];
            end
            w_valid = 1;
        end
        ph = (k / TICK) % 16;
        id = (k / (16 * TICK)) % DIGITS;
        if (ph < int'(br) && m_en[id]) begin
            exp_an  = '1;
            exp_an[id] = 1'b0;
            exp_seg = seg_of(m_nib[id]);
            exp_dp  = ~m_dp[id];
        end else begin
            exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1;
        end
        exp_fd = (k % FRAME == FRAME - 1);
        k++;
    endtask

    task automatic compare_outputs();
        check("seg_n", 32'(bus.seg_n), 32'(exp_seg));
        check("dp_n", 32'(bus.dp_n), 32'(exp_dp));
        check("an_n", 32'(bus.an_n), 32'(exp_an));
        check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    endtask

    // Called at a falling edge; returns at the next falling edge after checking
    task automatic run_cycle(input bit we, input logic [31:0] wd, input logic [7:0] dp,
                             input logic [7:0] en);
        bus.we = we; bus.wd = wd; bus.dp_wd = dp; bus.en_wd = en;
        bus.brightness = bright;
        @(posedge clk);
        model_edge(we, wd, dp, en, bright);
        @(negedge clk);
        compare_outputs();
        bus.we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, $urandom, 8'($urandom), 8'($urandom));
    endtask

    // Asserted between edges: outputs must drop dark without waiting for a clock
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_outputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare_outputs();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        bus.we = 1'b0; bus.wd = '0; bus.dp_wd = '0; bus.en_wd = '0;
        bright = 4'd15;
        bus.brightness = bright;
        model_reset();
        @(negedge clk);
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Unwritten display stays dark; frame_done every frame
        idle(400);

        // Digits 3..0 with full brightness
        run_cycle(1'b1, 32'h0000_3210, 8'h05, 8'h0F);
        idle(300);

        bright = 4'd4;
        idle(FRAME);
        bright = 4'd0;
        idle(FRAME);
        bright = 4'd15;

        // Two writes in one frame: only the last is ever shown
        while (k % FRAME != 40) idle(1);
        run_cycle(1'b1, 32'h8888_8888, 8'h00, 8'h0F);
        idle(10);
        run_cycle(1'b1, 32'hFFFF_FFFF, 8'h0A, 8'h0F);
        idle(2 * FRAME);

        // Write exactly on the frame_done cycle
        while (k % FRAME != 0) idle(1);
        check("fd_at_write", 32'(bus.frame_done), 32'd1);
        run_cycle(1'b1, 32'h0000_ACE1, 8'h09, 8'h0B);
        idle(FRAME + 20);

        // Randomized writes and brightness
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) bright = 4'($urandom);
            run_cycle($urandom_range(0, 49) == 0, $urandom, 8'($urandom), 8'($urandom));
        end

        // Reset mid-slot with a write still pending: it must never appear
        while (k % FRAME != 70) idle(1);
        bright = 4'd15;
        run_cycle(1'b1, 32'h0000_7777, 8'h0F, 8'h0F);
        idle(5);
        apply_reset();
        idle(300);
        run_cycle(1'b1, 32'h0000_B5D9, 8'h03, 8'h0C);
        idle(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
